// File: rtl/data_ram_responder_if.sv
// ---------------------------------------------------------------------------
// data_ram_responder_if
//
// Request/response bundle between the write-back data cache (master) and the
// RAM responder (slave).
//
// Signals:
//   en       master -> slave  request strobe, sampled only while the slave idles
//   wen      master -> slave  1 = write, 0 = read
//   byte_en  master -> slave  1 = byte write into lane addr[1:0], 0 = word write
//   addr     master -> slave  byte address
//   wdata    master -> slave  write data (byte writes use wdata[7:0])
//   rdata    slave -> master  registered read data
//   ready    slave -> master  one-cycle pulse in the cycle an access completes
//   busy     slave -> master  high while an accepted request is waiting
//   err      slave -> master  out-of-range pulse alongside ready
//                             (present only with DATA_RAM_RANGE_CHK_EN defined)
// ---------------------------------------------------------------------------
interface data_ram_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic                  en;
   logic                  wen;
   logic                  byte_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;
   logic                  busy;

`ifdef DATA_RAM_RANGE_CHK_EN
   logic                  err;

   // Cache side: issues requests, observes completion and range errors
   modport master (
      output en, wen, byte_en, addr, wdata,
      input  rdata, ready, busy, err
   );

   // Memory side: consumes requests, reports completion and range errors
   modport slave (
      input  en, wen, byte_en, addr, wdata,
      output rdata, ready, busy, err
   );
`else
   // Cache side: issues requests, observes completion
   modport master (
      output en, wen, byte_en, addr, wdata,
      input  rdata, ready, busy
   );

   // Memory side: consumes requests, reports completion
   modport slave (
      input  en, wen, byte_en, addr, wdata,
      output rdata, ready, busy
   );
`endif

endinterface

// File: rtl/data_ram_responder.sv
// ---------------------------------------------------------------------------
// data_ram_responder
//
// Memory-side responder for the data cache's RAM port. Holds a word-addressed
// storage array and runs every access through an IDLE/WAIT FSM that inserts
// WAIT_CYCLES extra cycles before completion. With WAIT_CYCLES = 0 the access
// happens at the accept edge, so read data and ready appear the next cycle.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (storage contents are not reset)
//   bus    data_ram_responder_if.slave: en/wen/byte_en/addr/wdata in,
//          rdata/ready/busy (and err when enabled) out
//
// Optional feature: define DATA_RAM_RANGE_CHK_EN to reject addresses whose
// bits above the word index are nonzero (write discarded, read returns 0,
// err pulses with ready). Without it the address wraps modulo DEPTH_WORDS*4.
// ---------------------------------------------------------------------------
module data_ram_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_ram_responder_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [3:0]            cnt;

   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic                  lat_wen;
   logic                  lat_be;

   logic                  accept;
   logic                  do_access;
   logic                  use_live;
   logic                  load_cnt;

   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic                  acc_wen;
   logic                  acc_be;
   logic [IDX_W-1:0]      acc_idx;
   logic [1:0]            acc_lane;
   logic [ADDR_WIDTH-IDX_W-3:0] acc_high;
   logic                  in_range;

   logic [3:0]            wr_mask;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  mem_we;

   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  ready_q;
   logic                  err_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   // State register; reset drops any pending access by returning to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and control decode. With no wait states the access is done
   // straight from the live bus inputs at the accept edge and the FSM never
   // leaves IDLE; otherwise the request is latched and completed from WAIT
   // once the countdown reaches zero. Requests arriving during WAIT are ignored.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      do_access  = 1'b0;
      use_live   = 1'b0;
      load_cnt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.en) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  do_access = 1'b1;
                  use_live  = 1'b1;
               end else begin
                  next_state = WAIT;
                  load_cnt   = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               do_access  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Select the request being serviced (live inputs or the latched copy) and
   // split its address into word index, byte lane and out-of-range bits.
   // Byte writes replicate wdata[7:0] across all lanes and enable one lane.
   assign acc_addr  = use_live ? bus.addr    : lat_addr;
   assign acc_wdata = use_live ? bus.wdata   : lat_wdata;
   assign acc_wen   = use_live ? bus.wen     : lat_wen;
   assign acc_be    = use_live ? bus.byte_en : lat_be;
   assign acc_idx   = acc_addr[IDX_W+1:2];
   assign acc_lane  = acc_addr[1:0];
   assign acc_high  = acc_addr[ADDR_WIDTH-1:IDX_W+2];
   assign wr_mask   = acc_be ? (4'b0001 << acc_lane) : 4'b1111;
   assign wr_data   = acc_be ? {4{acc_wdata[7:0]}} : acc_wdata;

`ifdef DATA_RAM_RANGE_CHK_EN
   assign in_range  = (acc_high == '0);
`else
   logic unused_high;
   assign in_range    = 1'b1;
   assign unused_high = ^acc_high;
`endif

   // The write enable is qualified with rst_n so an en held high during reset
   // cannot slip a write into the array.
   assign mem_we = rst_n && do_access && acc_wen && in_range;

   // Storage array with per-byte write enables; deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_mask[b]) begin
               mem[acc_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   // Response registers, request latch and wait counter. rdata only changes
   // when a read completes, so it holds the last read value across writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         cnt       <= 4'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wen   <= 1'b0;
         lat_be    <= 1'b0;
      end else begin
         ready_q <= do_access;
         err_q   <= do_access && !in_range;
         if (do_access && !acc_wen) begin
            rdata_q <= in_range ? mem[acc_idx] : '0;
         end
         if (accept) begin
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            lat_wen   <= bus.wen;
            lat_be    <= bus.byte_en;
         end
         if (load_cnt) begin
            cnt <= CNT_LOAD;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.busy  = (state == WAIT);

`ifdef DATA_RAM_RANGE_CHK_EN
   assign bus.err = err_q;
`else
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_ram_responder
//
// Drives two responders side by side (WAIT_CYCLES = 0 and WAIT_CYCLES = 3)
// with directed requests. A transaction-level model tracks memory contents and
// when each accepted request must complete; every cycle both DUTs' outputs are
// compared against it, and a few literal values pin the model.
// ---------------------------------------------------------------------------
module tb_data_ram_responder;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst_n;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   data_ram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   data_ram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

   data_ram_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );

   data_ram_responder #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   int checks = 0;
   int errors = 0;
   int edge_k = 0;

   logic [31:0] mem_m [int];

   bit          pend_v     [2];
   int          pend_edge  [2];
   logic        pend_wen   [2];
   logic        pend_be    [2];
   logic [31:0] pend_addr  [2];
   logic [31:0] pend_wdata [2];

   logic        exp_ready [2];
   logic        exp_busy  [2];
   logic        exp_err   [2];
   logic [31:0] exp_rdata [2];

   logic        in_en    [2];
   logic        in_wen   [2];
   logic        in_be    [2];
   logic [31:0] in_addr  [2];
   logic [31:0] in_wdata [2];

   function automatic int waitOf(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // One comparison: counts it, reports a FAIL line on mismatch
   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Apply one access to the model memory of DUT d and set its expected response
   task automatic modelAccess(input int d, input logic w, input logic be,
                              input logic [31:0] a, input logic [31:0] wd);
      int          word;
      int          key;
      int          lane;
      bit          inr;
      logic [31:0] old;
      word = int'((a >> 2) & 32'(DEPTH - 1));
`ifdef DATA_RAM_RANGE_CHK_EN
      inr = ((a / 32'(DEPTH * 4)) == 32'd0);
`else
      inr = 1'b1;
`endif
      key  = d * DEPTH + word;
      lane = int'(a[1:0]);
      exp_ready[d] = 1'b1;
      exp_err[d]   = !inr;
      if (w) begin
         if (inr) begin
            if (be) begin
               old = mem_m.exists(key) ? mem_m[key] : 32'h0;
               old[lane*8 +: 8] = wd[7:0];
               mem_m[key] = old;
            end else begin
               mem_m[key] = wd;
            end
         end
      end else begin
         exp_rdata[d] = (inr && mem_m.exists(key)) ? mem_m[key] : 32'h0;
      end
   endtask

   // Advance the model by one rising edge using the inputs applied before it.
   // A request accepted at edge k completes at edge k + WAIT_CYCLES.
   task automatic modelStep();
      edge_k++;
      for (int d = 0; d < 2; d++) begin
         exp_ready[d] = 1'b0;
         exp_err[d]   = 1'b0;
         if (pend_v[d] && pend_edge[d] == edge_k) begin
            pend_v[d] = 1'b0;
            modelAccess(d, pend_wen[d], pend_be[d], pend_addr[d], pend_wdata[d]);
         end else if (!pend_v[d] && in_en[d]) begin
            if (waitOf(d) == 0) begin
               modelAccess(d, in_wen[d], in_be[d], in_addr[d], in_wdata[d]);
            end else begin
               pend_v[d]     = 1'b1;
               pend_edge[d]  = edge_k + waitOf(d);
               pend_wen[d]   = in_wen[d];
               pend_be[d]    = in_be[d];
               pend_addr[d]  = in_addr[d];
               pend_wdata[d] = in_wdata[d];
            end
         end
         exp_busy[d] = pend_v[d];
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         pend_v[d]    = 1'b0;
         exp_ready[d] = 1'b0;
         exp_busy[d]  = 1'b0;
         exp_err[d]   = 1'b0;
         exp_rdata[d] = 32'h0;
      end
   endtask

   task automatic driveBus();
      bus0.en      = in_en[0];
      bus0.wen     = in_wen[0];
      bus0.byte_en = in_be[0];
      bus0.addr    = in_addr[0];
      bus0.wdata   = in_wdata[0];
      bus3.en      = in_en[1];
      bus3.wen     = in_wen[1];
      bus3.byte_en = in_be[1];
      bus3.addr    = in_addr[1];
      bus3.wdata   = in_wdata[1];
   endtask

   // Compare both DUTs against the model
   task automatic checkOutput();
      compare($sformatf("d0_ready@%0d", edge_k), 32'(bus0.ready), 32'(exp_ready[0]));
      compare($sformatf("d0_busy@%0d",  edge_k), 32'(bus0.busy),  32'(exp_busy[0]));
      compare($sformatf("d0_rdata@%0d", edge_k), bus0.rdata,      exp_rdata[0]);
      compare($sformatf("d3_ready@%0d", edge_k), 32'(bus3.ready), 32'(exp_ready[1]));
      compare($sformatf("d3_busy@%0d",  edge_k), 32'(bus3.busy),  32'(exp_busy[1]));
      compare($sformatf("d3_rdata@%0d", edge_k), bus3.rdata,      exp_rdata[1]);
`ifdef DATA_RAM_RANGE_CHK_EN
      compare($sformatf("d0_err@%0d", edge_k), 32'(bus0.err), 32'(exp_err[0]));
      compare($sformatf("d3_err@%0d", edge_k), 32'(bus3.err), 32'(exp_err[1]));
`endif
   endtask

   // Drive one cycle of inputs into DUT d (the other DUT idles), clock it,
   // step the model and check at the following falling edge
   task automatic applyStimulus(input int d, input logic en, input logic w, input logic be,
                                input logic [31:0] a, input logic [31:0] wd);
      for (int i = 0; i < 2; i++) begin
         in_en[i]    = (i == d) ? en : 1'b0;
         in_wen[i]   = (i == d) ? w  : 1'b0;
         in_be[i]    = (i == d) ? be : 1'b0;
         in_addr[i]  = (i == d) ? a  : 32'h0;
         in_wdata[i] = (i == d) ? wd : 32'h0;
      end
      driveBus();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Asynchronous reset asserted at a falling edge, held over one rising edge
   task automatic doReset();
      for (int i = 0; i < 2; i++) in_en[i] = 1'b0;
      driveBus();
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput();
      @(posedge clk);
      @(negedge clk);
      checkOutput();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         in_en[i] = 1'b0; in_wen[i] = 1'b0; in_be[i] = 1'b0;
         in_addr[i] = 32'h0; in_wdata[i] = 32'h0;
      end
      driveBus();
      rst_n = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput();
      compare("reset_rdata0", bus0.rdata, 32'h0);
      compare("reset_ready3", 32'(bus3.ready), 32'h0);
      rst_n = 1'b1;
      idle(1);

      $display("[TB] zero-wait write then read");
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
      compare("lit_wr40_ready", 32'(bus0.ready), 32'h1);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
      compare("lit_rd40_rdata", bus0.rdata, 32'hDEADBEEF);
      idle(1);

      $display("[TB] byte lane merge");
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h80, 32'h11223344);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h82, 32'hFFFFFFAA);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h83, 32'h0);
      compare("lit_merge_lane2", bus0.rdata, 32'h11AA3344);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h81, 32'h000000CC);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h83, 32'h0000005A);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h80, 32'h12345601);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
      compare("lit_merge_all", bus0.rdata, 32'h5AAACC01);
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0BADF00D);
      compare("lit_write_keeps_rdata", bus0.rdata, 32'h5AAACC01);

      $display("[TB] back-to-back alternating writes and reads");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'hA5A50000 + 32'(i));
         applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
      end
      compare("lit_b2b_last", bus0.rdata, 32'hA5A50003);
      idle(1);

      $display("[TB] high address bits");
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D);
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h12345678);
`ifdef DATA_RAM_RANGE_CHK_EN
      compare("lit_oor_wr_err", 32'(bus0.err), 32'h1);
      compare("lit_oor_wr_ready", 32'(bus0.ready), 32'h1);
`endif
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DATA_RAM_RANGE_CHK_EN
      compare("lit_word0_kept", bus0.rdata, 32'hCAFEF00D);
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h0);
      compare("lit_oor_rd_rdata", bus0.rdata, 32'h0);
      compare("lit_oor_rd_err", 32'(bus0.err), 32'h1);
`else
      compare("lit_word0_wrapped", bus0.rdata, 32'h12345678);
`endif
      idle(1);

      $display("[TB] three wait states");
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h77);
      idle(4);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      compare("lit_w3_busy_t1", 32'(bus3.busy), 32'h1);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      compare("lit_w3_busy_t2", 32'(bus3.busy), 32'h1);
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h99);
      compare("lit_w3_busy_t3", 32'(bus3.busy), 32'h1);
      compare("lit_w3_noready_t3", 32'(bus3.ready), 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      compare("lit_w3_ready_t4", 32'(bus3.ready), 32'h1);
      compare("lit_w3_rdata_t4", bus3.rdata, 32'h77);
      idle(5);

      $display("[TB] reset during wait");
      applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h55);
      idle(1);
      doReset();
      idle(2);
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      idle(3);
      compare("lit_reset_drop_ready", 32'(bus3.ready), 32'h1);
      compare("lit_reset_drop_rdata", bus3.rdata, 32'h77);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Memory-side responder for the write-back data cache's RAM port; serves the cache's word reads (line fills) and word/byte writes (dirty evictions).
- Holds a word-addressed storage array and runs each access through a small request/wait/complete FSM.
- Wait-state count is configurable. At zero wait states, read data is valid the cycle after the request, which is the timing the cache's LOAD state expects.
- Drives a busy indication so a cache or arbiter can hold off new requests.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; fixed at 32 for byte-lane logic
DEPTH_WORDS, 1024, number of storage words; power of two
WAIT_CYCLES, 0, extra cycles inserted before each access completes (0..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  request strobe; sampled only when idle
wen  input  1  1 = write, 0 = read
byte_en  input  1  1 = byte write using addr[1:0]; 0 = full-word write; ignored on reads
addr  input  ADDR_WIDTH  byte address; word index = addr[log2(DEPTH_WORDS)+1:2]
wdata  input  DATA_WIDTH  write data; byte writes use wdata[7:0]
rdata  output  DATA_WIDTH  read data; registered
ready  output  1  one-cycle pulse in the cycle the access completes
busy  output  1  high while an accepted request is waiting

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rdata=0, ready=0, busy=0, wait counter=0, latched request cleared. Storage array contents are not reset.
- FSM states: IDLE, WAIT.
- IDLE, en=1 at a rising edge: latch addr, wdata, wen, byte_en.
  - WAIT_CYCLES=0: perform the access at this same edge. ready=1 in the next cycle; for a read, rdata holds mem[word] in that cycle. Stay in IDLE, so back-to-back requests on consecutive cycles are each accepted.
  - WAIT_CYCLES>0: go to WAIT, load counter=WAIT_CYCLES-1, busy=1.
- WAIT: counter decrements each edge. At the edge where the counter is 0: perform the access with the latched values, ready=1 next cycle, busy=0, go to IDLE. en during WAIT is ignored: no queueing, no error.
- Total latency from accept edge to ready cycle: WAIT_CYCLES+1 cycles.
- Word write: mem[word] <= wdata.
- Byte write, little-endian: lane addr[1:0]=0 maps to bits [7:0] ... lane 3 maps to bits [31:24]. Only that lane is updated; the other three bytes keep their value.
- Read: rdata <= mem[word]; rdata holds that value until the next read completes. Writes never change rdata. ready pulses for both reads and writes.
- addr[1:0] is ignored for word accesses; misaligned word access = aligned access.
- Address bits above the word index: behaviour depends on DATA_RAM_RANGE_CHK_EN (see Optional Feature).
- Read and write to the same word on consecutive accepted requests: the read returns the newly written value; no stale read.
- Reset mid-WAIT: the pending access is dropped. No storage update, no ready pulse; FSM returns to IDLE.

Optional Feature:
Macro DATA_RAM_RANGE_CHK_EN.
- Defined: adds output port err (1 bit, reset 0).
  - A request whose addr bits above the word index are nonzero is out of range.
  - At completion, an out-of-range write is discarded, and an out-of-range read sets rdata=0.
  - err pulses high in the same cycle as ready.
- Undefined: no err port. High address bits are ignored and the address wraps modulo DEPTH_WORDS*4.

Test Plan:
- WAIT_CYCLES=0: write word 0xDEADBEEF at 0x40, read 0x40 next cycle -> ready pulses each cycle after the request; rdata=0xDEADBEEF in the cycle after the read request.
- Byte merge: word write 0x11223344 at 0x80, byte write wdata=0xAA at 0x82, read 0x80 -> rdata=0x11AA3344.
- WAIT_CYCLES=3: read request at cycle t -> busy=1 for cycles t+1..t+3, ready=1 only at t+4; an en pulse at t+2 produces no extra ready.
- Reset mid-wait: WAIT_CYCLES=3 write 0x55 to 0x10 (0x10 previously holding 0x77), assert rst_n low at t+2, then read 0x10 -> rdata=0x77, no ready pulse before the read.
- Range check (DATA_RAM_RANGE_CHK_EN, DEPTH_WORDS=1024): write to 0x1000 then read 0x0000 -> word 0 unchanged; write request has err=1 with ready; read of 0x1000 gives rdata=0, err=1. Without the macro, the same write lands in word 0.
- Back-to-back alternating writes/reads to 4 sequential words at WAIT_CYCLES=0 -> one ready per request, read values match the preceding writes, no dropped requests.
